// File: rtl/ser2par_collect.sv
// rtl/ser2par_collect.sv - packs DWO-bit words into one DWI-bit vector behind a collect + hold stage pair
module ser2par_collect #(
   parameter  int DWI = 7*32,
   parameter  int DWO = 32,
   localparam int NW  = DWI/DWO,
   localparam int CW  = $clog2(NW+1)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [DWO-1:0] in_data,
   input  logic           in_last,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [DWI-1:0] out_data,
   output logic [CW-1:0]  out_cnt
);

   typedef enum logic {S_COLLECT, S_PEND} state_t;

   state_t         state, state_nx;
   logic           rdy_en;
   logic [DWI-1:0] coll_data;
   logic [DWI-1:0] grp_data;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_inc;
   logic           accept;
   logic           complete;
   logic           free;
   logic           xfer_pend;
   logic           xfer_new;

   // rdy_en keeps in_ready low while reset is held and for the release edge itself
   assign in_ready  = rdy_en & (state == S_COLLECT);
   assign accept    = in_valid & in_ready;
   assign cnt_inc   = cnt + CW'(1);
   assign complete  = accept & (in_last | (cnt == CW'(NW-1)));
   assign free      = !out_valid | out_ready;
   assign xfer_pend = (state == S_PEND) & free;
   assign xfer_new  = complete & free;

   always_comb begin
      grp_data = coll_data;
      for (int k = 0; k < NW; k++) begin
         if (cnt == CW'(k)) grp_data[k*DWO +: DWO] = in_data;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_COLLECT: if (complete && !free) state_nx = S_PEND;
         S_PEND:    if (free)              state_nx = S_COLLECT;
         default:                          state_nx = S_COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_COLLECT;
         rdy_en <= 1'b0;
      end else begin
         state  <= state_nx;
         rdy_en <= 1'b1;
      end
   end

   // A pending group and a new accept are mutually exclusive since in_ready is low in S_PEND
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coll_data <= '0;
         cnt       <= '0;
         out_data  <= '0;
         out_cnt   <= '0;
         out_valid <= 1'b0;
      end else if (xfer_pend) begin
         out_data  <= coll_data;
         out_cnt   <= cnt;
         out_valid <= 1'b1;
         coll_data <= '0;
         cnt       <= '0;
      end else if (xfer_new) begin
         out_data  <= grp_data;
         out_cnt   <= cnt_inc;
         out_valid <= 1'b1;
         coll_data <= '0;
         cnt       <= '0;
      end else begin
         if (accept) begin
            coll_data <= grp_data;
            cnt       <= cnt_inc;
         end
         if (out_ready) out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ser2par_collect.sv
// tb/tb_ser2par_collect.sv - self-checking bench for ser2par_collect
module tb_ser2par_collect;

   localparam int DWI = 7*32;
   localparam int DWO = 32;
   localparam int NW  = DWI/DWO;
   localparam int CW  = $clog2(NW+1);

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [DWO-1:0] in_data = '0;
   logic           in_last = 1'b0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [DWI-1:0] out_data;
   logic [CW-1:0]  out_cnt;

   ser2par_collect #(.DWI(DWI), .DWO(DWO)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_cnt(out_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   // Reference: words of the open group, and completed groups not yet taken by the consumer
   logic [DWO-1:0] cur[$];
   logic [DWI-1:0] exp_v[$];
   logic [CW-1:0]  exp_c[$];

   typedef struct {
      int   n;
      bit   last;
      bit   ordy;
      int   exp_cnt;
   } vec_t;

   task automatic chk(input string nm, input logic [DWI-1:0] act, input logic [DWI-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_push(input logic [DWO-1:0] d, input logic l);
      logic [DWI-1:0] v;
      cur.push_back(d);
      if (cur.size() == NW || l) begin
         v = '0;
         foreach (cur[i]) v[i*DWO +: DWO] = cur[i];
         exp_v.push_back(v);
         exp_c.push_back(CW'(cur.size()));
         cur.delete();
      end
   endtask

   // One clock: check outputs at the falling edge, advance the model at the rising edge
   task automatic cycle(output bit acc);
      bit hs;
      logic [DWO-1:0] d;
      logic l;
      @(negedge clk);
      if (chk_en) begin
         chk("out_valid", DWI'(out_valid), DWI'(exp_v.size() > 0));
         chk("in_ready", DWI'(in_ready), DWI'(exp_v.size() < 2));
         if (exp_v.size() > 0) begin
            chk("out_data", out_data, exp_v[0]);
            chk("out_cnt", DWI'(out_cnt), DWI'(exp_c[0]));
         end
      end
      acc = in_valid & in_ready;
      hs  = out_valid & out_ready;
      d   = in_data;
      l   = in_last;
      @(posedge clk);
      cyc++;
      if (hs && exp_v.size() > 0) begin
         void'(exp_v.pop_front());
         void'(exp_c.pop_front());
      end
      if (acc) model_push(d, l);
      #1;
   endtask

   task automatic send_word(input logic [DWO-1:0] d, input logic l);
      bit acc;
      int n;
      in_valid = 1'b1; in_data = d; in_last = l;
      n = 0;
      do begin
         cycle(acc);
         n++;
      end while (!acc && n < 200);
      if (!acc) begin
         total++; bad++;
         $display("FAIL send_timeout: got no accept want accept within 200 cycles");
      end
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic idle(input int n);
      bit acc;
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) cycle(acc);
   endtask

   task automatic drain();
      int n;
      bit acc;
      out_ready = 1'b1;
      n = 0;
      while (exp_v.size() > 0 && n < 100) begin
         cycle(acc);
         n++;
      end
      chk("drain_empty", DWI'(exp_v.size()), DWI'(0));
   endtask

   task automatic do_reset();
      chk_en = 1'b0;
      #1 rst_n = 1'b0;
      in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", DWI'(out_valid), DWI'(0));
      chk("rst_out_data", out_data, DWI'(0));
      chk("rst_out_cnt", DWI'(out_cnt), DWI'(0));
      chk("rst_in_ready", DWI'(in_ready), DWI'(0));
      cur.delete(); exp_v.delete(); exp_c.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk_en = 1'b1;
   endtask

   localparam logic [DWI-1:0] SEQ1_VEC =
      224'h00000077_00000066_00000055_00000044_00000033_00000022_00000011;

   initial begin
      vec_t tbl[$];
      logic [DWO-1:0] a, b, c;
      int c0;
      bit acc;

      do_reset();

      // Seven consecutive words form one full vector, word0 in the LSBs
      out_ready = 1'b1;
      for (int i = 0; i < NW; i++) send_word(DWO'(32'h11 * (i+1)), 1'b0);
      chk("seq1_valid", DWI'(out_valid), DWI'(1));
      chk("seq1_vec", out_data, SEQ1_VEC);
      chk("seq1_cnt", DWI'(out_cnt), DWI'(7));
      idle(2);

      // Short group closed by in_last, then next word starts at slot 0
      a = 32'hAAAA0001; b = 32'hBBBB0002; c = 32'hCCCC0003;
      send_word(a, 1'b0); send_word(b, 1'b0); send_word(c, 1'b1);
      chk("seq2_vec", out_data, {128'h0, c, b, a});
      chk("seq2_cnt", DWI'(out_cnt), DWI'(3));
      send_word(32'hD00D0004, 1'b1);
      chk("seq2_slot0", DWI'(out_data[31:0]), DWI'(32'hD00D0004));
      chk("seq2_cnt1", DWI'(out_cnt), DWI'(1));
      idle(2);

      // 14 back-to-back words must take exactly 14 cycles
      c0 = cyc;
      for (int i = 0; i < 2*NW; i++) send_word($urandom, 1'b0);
      chk("b2b_cycles", DWI'(cyc - c0), DWI'(2*NW));
      idle(2);

      // Backpressure: second group parks in the collect stage, held input is ignored
      for (int i = 0; i < NW; i++) send_word($urandom, 1'b0);
      out_ready = 1'b0;
      for (int i = 0; i < NW; i++) send_word($urandom, 1'b0);
      chk("bp_in_ready", DWI'(in_ready), DWI'(0));
      in_valid = 1'b1; in_data = 32'hDEADBEEF; in_last = 1'b1;
      for (int i = 0; i < 3; i++) cycle(acc);
      in_valid = 1'b0; in_last = 1'b0;
      out_ready = 1'b1;
      cycle(acc);
      chk("bp_v2_valid", DWI'(out_valid), DWI'(1));
      chk("bp_in_ready_back", DWI'(in_ready), DWI'(1));
      drain();

      // Consumer takes vector 1 on the same edge group 2 completes
      for (int i = 0; i < NW; i++) send_word($urandom, 1'b0);
      out_ready = 1'b0;
      for (int i = 0; i < NW-1; i++) send_word($urandom, 1'b0);
      out_ready = 1'b1;
      send_word(32'h5A5A5A5A, 1'b0);
      chk("same_edge_valid", DWI'(out_valid), DWI'(1));
      chk("same_edge_top", DWI'(out_data[DWI-1 -: DWO]), DWI'(32'h5A5A5A5A));
      drain();

      // Table of group shapes
      tbl.push_back('{n: 7, last: 1'b0, ordy: 1'b1, exp_cnt: 7});
      tbl.push_back('{n: 7, last: 1'b1, ordy: 1'b1, exp_cnt: 7});
      tbl.push_back('{n: 1, last: 1'b1, ordy: 1'b1, exp_cnt: 1});
      tbl.push_back('{n: 6, last: 1'b1, ordy: 1'b0, exp_cnt: 6});
      tbl.push_back('{n: 2, last: 1'b1, ordy: 1'b0, exp_cnt: 2});
      tbl.push_back('{n: 5, last: 1'b1, ordy: 1'b1, exp_cnt: 5});
      foreach (tbl[t]) begin
         out_ready = tbl[t].ordy;
         for (int i = 0; i < tbl[t].n; i++)
            send_word($urandom, (i == tbl[t].n-1) ? tbl[t].last : 1'b0);
         chk("tbl_cnt", DWI'(out_cnt), DWI'(tbl[t].exp_cnt));
         drain();
      end

      // Reset mid-group, and reset with a vector held
      for (int i = 0; i < 4; i++) send_word($urandom, 1'b0);
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < NW; i++) send_word(DWO'(32'h11 * (i+1)), 1'b0);
      chk("rst1_vec", out_data, SEQ1_VEC);
      out_ready = 1'b0;
      idle(1);
      do_reset();
      for (int i = 0; i < NW; i++) send_word(DWO'(32'h11 * (i+1)), 1'b0);
      chk("rst2_vec", out_data, SEQ1_VEC);
      chk("rst2_cnt", DWI'(out_cnt), DWI'(7));
      drain();

      // Random traffic; the source holds its word until accepted
      acc = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (acc || !in_valid) begin
            in_valid = ($urandom % 4) != 0;
            in_data  = $urandom;
            in_last  = ($urandom % 6) == 0;
         end
         out_ready = ($urandom % 3) != 0;
         cycle(acc);
      end
      in_valid = 1'b0; in_last = 1'b0;
      if (cur.size() > 0) send_word($urandom, 1'b1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
